buffer_ctrl: RTL and testbench
==============================

Name: buffer_ctrl

Overview:
- Sequencer for the 2^14 x 32-bit operand buffer that feeds the systolic array.
- Accepts a job of N words from a host valid/ready stream and drives the buffer's 2-bit state command to store them.
- Then drives the buffer to stream them as 64-bit pairs to the array under array back-pressure.
- Owns all buffer command sequencing, so the buffer never sees a Store and a Stream in the same cycle.

Parameters:
- DATA_W, 32, host/buffer word width.
- ADDR_W, 14, buffer address width.
- DEPTH, 16384, buffer capacity in words.
- SETTLE, 2, idle cycles between the last store and the first stream command; covers the buffer's registered count/flag lag.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job start pulse, sampled in IDLE only
- load_len  in  15  job length in words; must be even, in 2..DEPTH
- in_valid  in  1  host word valid
- in_data  in  DATA_W  host word
- in_ready  out  1  host word accepted when in_valid&&in_ready
- buf_full  in  1  buffer full flag
- buf_empty  in  1  buffer empty flag
- buf_state  out  2  buffer command: 00 nop, 01 store, 10 stream
- buf_addr  out  ADDR_W  current write index (LOAD) or read index (STREAM); informational
- buf_data  out  DATA_W  word to store (equals in_data)
- sa_ready  in  1  array can take a pair this cycle
- out_valid  out  1  buffer data_out holds a valid pair this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- States: IDLE, LOAD, SETTLE, STREAM, DRAIN, DONE. Registered state, wr_cnt[14:0], rd_cnt[14:0], len[14:0].
- Reset (sync): state=IDLE, all counters 0, out_valid=0, done=0, err=0. Combinational outputs resolve to their IDLE values: buf_state=00, in_ready=0, busy=0. The buffer shares the same reset.
- IDLE:
  - start with load_len even, nonzero and <=DEPTH: latch len, clear counters, go to LOAD.
  - Otherwise start pulses err for 1 cycle and the block stays in IDLE.
- start outside IDLE is ignored and does not set err.
- LOAD:
  - in_ready = !buf_full.
  - On handshake: buf_state=01 (combinational, same cycle), buf_data=in_data, buf_addr=wr_cnt[13:0], then wr_cnt++.
  - No handshake: buf_state=00.
  - Handshake with wr_cnt==len-1: go to SETTLE.
- SETTLE: buf_state=00, in_ready=0 for SETTLE cycles, then go to STREAM.
- STREAM:
  - Issue when sa_ready && !buf_empty && rd_cnt<len.
  - Issue: buf_state=10, buf_addr=rd_cnt[13:0], then rd_cnt+=2.
  - Otherwise buf_state=00.
  - Issue with rd_cnt==len-2: go to DRAIN.
- out_valid is registered: high exactly one cycle after each issue, low otherwise. The buffer zeroes data_out on a nop, so the pair is valid for one cycle only.
- DRAIN: 1 cycle, buf_state=00, then go to DONE.
- DONE: done=1 for 1 cycle, then go to IDLE.
- The controller never drives 01 and 10 in the same cycle and never streams past len, even if buf_empty stays low.
- Boundary conditions:
  - len=DEPTH: exactly fills the buffer. buf_full rising during the last write is tolerated because the last accept has already occurred.
  - Counters are 15-bit; buf_addr wraps modulo DEPTH.
  - sa_ready low in STREAM: stall, buf_state=00, counters hold.
  - buf_full high in LOAD: in_ready=0, wait.
  - Reset mid-job: immediate return to IDLE, no done pulse.
- Latency: first stream command issues SETTLE+1 cycles after the last store, or later if sa_ready is low.

Optional Feature:
- Macro: BUF_CTRL_PERF_EN.
- Defined: adds output stall_cnt[15:0].
  - Counts STREAM cycles where rd_cnt<len and no issue occurred; saturates at 0xFFFF.
  - Clears on accepted start and on reset.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- start, load_len=4, words 0xA,0xB,0xC,0xD back-to-back, sa_ready=1 -> four cycles of buf_state=01; 2 nops; buf_state=10 on 2 cycles; out_valid pairs {A,B},{C,D}; done pulse; busy low afterwards.
- start with load_len=3, then load_len=0 -> err pulses twice, state stays IDLE, buf_state=00 throughout.
- load_len=8, in_valid toggling 1/0 -> exactly 8 stores, buf_addr 0..7, no store on in_valid=0 cycles.
- load_len=6, sa_ready low 5 cycles mid-stream -> no 10 command and out_valid=0 while low; resumes and completes 3 pairs; with BUF_CTRL_PERF_EN, stall_cnt=5.
- Reset asserted during STREAM after 1 pair -> next cycle IDLE, buf_state=00, out_valid=0, no done pulse; a new load_len=2 job then completes normally.
- load_len=16384 -> 16384 stores, in_ready stays high (buffer never reports full before the last accept), 8192 stream commands, done pulse.

Source files
------------

// File: rtl/buffer_ctrl.sv
// buffer_ctrl: load / settle / stream sequencer for the operand buffer feeding the systolic array.
// Optional macro BUF_CTRL_PERF_EN adds o_stall_cnt (saturating count of stalled stream cycles).
module buffer_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned SETTLE = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    input  logic              i_buf_full,
    input  logic              i_buf_empty,
    output logic [1:0]        o_buf_state,
    output logic [ADDR_W-1:0] o_buf_addr,
    output logic [DATA_W-1:0] o_buf_data,
    input  logic              i_sa_ready,
    output logic              o_out_valid,
    output logic              o_busy,
    output logic              o_done,
`ifdef BUF_CTRL_PERF_EN
    output logic [15:0]       o_stall_cnt,
`endif
    output logic              o_err
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_STORE  = 2'b01;
    localparam logic [1:0] CMD_STREAM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_len;
    logic [SET_W-1:0] r_settle_cnt;
    logic             r_out_valid;
    logic             r_done;
    logic             r_err;

    logic w_len_ok;
    logic w_accept_start;
    logic w_reject_start;
    logic w_store;
    logic w_issue;

    // Job length must be even and within 2..DEPTH.
    assign w_len_ok       = (i_load_len[0] == 1'b0) && (i_load_len != '0) &&
                            (i_load_len <= CNT_W'(DEPTH));
    assign w_accept_start = (r_state == S_IDLE) && i_start && w_len_ok;
    assign w_reject_start = (r_state == S_IDLE) && i_start && !w_len_ok;
    assign w_store        = (r_state == S_LOAD) && i_in_valid && !i_buf_full;
    assign w_issue        = (r_state == S_STREAM) && i_sa_ready && !i_buf_empty &&
                            (r_rd_cnt < r_len);

    assign o_busy      = (r_state != S_IDLE);
    assign o_buf_data  = i_in_data;
    assign o_out_valid = r_out_valid;
    assign o_done      = r_done;
    assign o_err       = r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and the same-cycle buffer command / host handshake.
    always_comb begin
        w_next_state = r_state;
        o_buf_state  = CMD_NOP;
        o_in_ready   = 1'b0;
        o_buf_addr   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept_start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                o_in_ready = !i_buf_full;
                o_buf_addr = r_wr_cnt[ADDR_W-1:0];
                if (w_store) begin
                    o_buf_state = CMD_STORE;
                    if (r_wr_cnt == (r_len - CNT_W'(1))) begin
                        w_next_state = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == SET_W'(SETTLE - 1)) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                o_buf_addr = r_rd_cnt[ADDR_W-1:0];
                if (w_issue) begin
                    o_buf_state = CMD_STREAM;
                    if (r_rd_cnt == (r_len - CNT_W'(2))) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_len        <= '0;
            r_settle_cnt <= '0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_out_valid <= w_issue;
            r_done      <= (w_next_state == S_DONE);
            r_err       <= w_reject_start;
            if (w_accept_start) begin
                r_len    <= i_load_len;
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
            end else begin
                if (w_store) begin
                    r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                end
                if (w_issue) begin
                    r_rd_cnt <= r_rd_cnt + CNT_W'(2);
                end
            end
            // Counts the idle gap that lets the buffer's count/flags catch up.
            if (r_state == S_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + SET_W'(1);
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

`ifdef BUF_CTRL_PERF_EN
    logic        w_stall;
    logic [15:0] r_stall_cnt;

    assign w_stall     = (r_state == S_STREAM) && (r_rd_cnt < r_len) && !w_issue;
    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_accept_start) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_buffer_ctrl.sv
// Self-checking bench for buffer_ctrl: job-level reference model checked every cycle plus directed literals.
module tb_buffer_ctrl;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DEPTH  = 16384;
    localparam int unsigned SETTLE = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              buf_full;
    logic              buf_empty;
    logic [1:0]        buf_state;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              sa_ready;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic              err;
`ifdef BUF_CTRL_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    buffer_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_load_len  (load_len),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .i_buf_full  (buf_full),
        .i_buf_empty (buf_empty),
        .o_buf_state (buf_state),
        .o_buf_addr  (buf_addr),
        .o_buf_data  (buf_data),
        .i_sa_ready  (sa_ready),
        .o_out_valid (out_valid),
        .o_busy      (busy),
        .o_done      (done),
`ifdef BUF_CTRL_PERF_EN
        .o_stall_cnt (stall_cnt),
`endif
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Job-level model: how many words stored/read, settle gap left, tail cycles left.
    bit m_busy = 0;
    int m_len = 0, m_stored = 0, m_read = 0, m_wait = 0, m_tail = 0;
    bit m_ov = 0, m_err = 0;
    int m_stall = 0;

    // Observations of the DUT, compared against literals by the directed tests.
    int mon_cyc = 0, mon_store = 0, mon_stream = 0, mon_nonnop = 0;
    int mon_done = 0, mon_done_cyc = 0, mon_err = 0, mon_busy = 0;
    int mon_addr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit len_ok(input int len);
        return (len % 2 == 0) && (len != 0) && (len <= int'(DEPTH));
    endfunction

    task automatic model_step();
        bit loading, settling, streaming, draining, finishing, store, issue;
        logic [1:0] e_state;
        if (reset) begin
            m_busy = 0; m_ov = 0; m_err = 0; m_stall = 0;
            m_len = 0; m_stored = 0; m_read = 0; m_wait = 0; m_tail = 0;
        end else begin
            loading   = m_busy && (m_stored < m_len);
            settling  = m_busy && (m_stored == m_len) && (m_wait > 0);
            streaming = m_busy && (m_stored == m_len) && (m_wait == 0) && (m_read < m_len);
            draining  = m_busy && (m_read == m_len) && (m_tail == 2);
            finishing = m_busy && (m_read == m_len) && (m_tail == 1);
            store     = loading && !buf_full && in_valid;
            issue     = streaming && sa_ready && !buf_empty;
            e_state   = store ? 2'b01 : (issue ? 2'b10 : 2'b00);

            chk("buf_state", 32'(buf_state), 32'(e_state));
            chk("in_ready",  32'(in_ready),  32'(loading && !buf_full));
            chk("busy",      32'(busy),      32'(m_busy));
            chk("done",      32'(done),      32'(finishing));
            chk("err",       32'(err),       32'(m_err));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (store) begin
                chk("store_addr", 32'(buf_addr), 32'(m_stored % int'(DEPTH)));
                chk("store_data", buf_data, in_data);
            end
            if (issue) chk("stream_addr", 32'(buf_addr), 32'(m_read % int'(DEPTH)));
`ifdef BUF_CTRL_PERF_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif

            if (buf_state == 2'b01) begin mon_store++; mon_addr_q.push_back(int'(buf_addr)); end
            if (buf_state == 2'b10) mon_stream++;
            if (buf_state != 2'b00) mon_nonnop++;
            if (done) begin mon_done++; mon_done_cyc = mon_cyc; end
            if (err) mon_err++;
            if (busy) mon_busy++;

            m_ov  = issue;
            m_err = !m_busy && start && !len_ok(int'(load_len));
            if (streaming && !issue && m_stall < 65535) m_stall++;
            if (!m_busy) begin
                if (start && len_ok(int'(load_len))) begin
                    m_busy = 1; m_len = int'(load_len); m_stored = 0; m_read = 0;
                    m_wait = int'(SETTLE); m_tail = 2; m_stall = 0;
                end
            end else if (loading) begin
                if (store) m_stored++;
            end else if (settling) begin
                m_wait--;
            end else if (streaming) begin
                if (issue) m_read += 2;
            end else if (draining) begin
                m_tail = 1;
            end else if (finishing) begin
                m_busy = 0;
            end
        end
        mon_cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // mode 0 free-flowing, 1 in_valid toggling, 2 sa_ready low k=10..14, 3 random, 4 full after last word.
    task automatic drive(input int mode, input int k);
        in_data   = $urandom;
        in_valid  = 1'b1;
        sa_ready  = 1'b1;
        buf_full  = 1'b0;
        buf_empty = 1'b0;
        if (k > 0) start = 1'b0;
        case (mode)
            1: in_valid = ((k % 2) == 1);
            2: sa_ready = !(k >= 10 && k <= 14);
            3: begin
                in_valid  = ($urandom_range(0, 3) != 0);
                sa_ready  = ($urandom_range(0, 9) < 7);
                buf_full  = ($urandom_range(0, 9) < 2);
                buf_empty = ($urandom_range(0, 9) < 2);
                if (k > 0 && $urandom_range(0, 19) == 0) begin
                    start    = 1'b1;
                    load_len = (ADDR_W+1)'($urandom);
                end
            end
            4: buf_full = (k > int'(DEPTH));
            default: ;
        endcase
    endtask

    task automatic go_idle();
        start = 1'b0; in_valid = 1'b0; sa_ready = 1'b0; buf_full = 1'b0; buf_empty = 1'b0;
    endtask

    task automatic run_job(input int len, input int mode, input int budget, output int done_off);
        int d0, c0;
        bit got;
        d0 = mon_done; c0 = mon_cyc; got = 0; done_off = -1;
        start = 1'b1; load_len = (ADDR_W+1)'(len);
        drive(mode, 0);
        tick();
        for (int k = 1; k <= budget && !got; k++) begin
            drive(mode, k);
            tick();
            if (mon_done != d0) got = 1;
        end
        go_idle();
        if (got) done_off = mon_done_cyc - c0;
        else begin
            chk("job_timeout", 32'(0), 32'(1));
            reset = 1'b1; tick(); reset = 1'b0;
        end
    endtask

    initial begin
        int off, s0, t0, d0, e0, n0, b0, q0, len;
        reset = 1'b1; go_idle(); load_len = '0; in_data = '0;
        repeat (3) tick();
        reset = 1'b0; in_valid = 1'b1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_buf_state", 32'(buf_state), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        tick();

        // Four words back-to-back, array always ready.
        s0 = mon_store; t0 = mon_stream;
        run_job(4, 0, 100, off);
        chk("t1_stores", 32'(mon_store - s0), 32'(4));
        chk("t1_streams", 32'(mon_stream - t0), 32'(2));
        chk("t1_done_cycle", 32'(off), 32'(10));
        tick();
        chk("t1_busy_after", 32'(busy), 32'(0));

        // Rejected starts: odd, zero, too long.
        e0 = mon_err; n0 = mon_nonnop; b0 = mon_busy;
        start = 1'b1; load_len = 15'd3; tick(); start = 1'b0; tick(); tick();
        start = 1'b1; load_len = 15'd0; tick(); start = 1'b0; tick(); tick();
        start = 1'b1; load_len = 15'd16386; tick(); start = 1'b0; tick(); tick();
        chk("t2_err_pulses", 32'(mon_err - e0), 32'(3));
        chk("t2_no_cmds", 32'(mon_nonnop - n0), 32'(0));
        chk("t2_never_busy", 32'(mon_busy - b0), 32'(0));

        // Gappy host stream.
        s0 = mon_store; mon_addr_q.delete();
        run_job(8, 1, 200, off);
        chk("t3_stores", 32'(mon_store - s0), 32'(8));
        for (int i = 0; i < 8; i++)
            chk("t3_addr", 32'((i < mon_addr_q.size()) ? mon_addr_q[i] : -1), 32'(i));
        tick();

        // Array back-pressure for five cycles after the first pair.
        t0 = mon_stream;
        run_job(6, 2, 200, off);
        chk("t4_streams", 32'(mon_stream - t0), 32'(3));
        chk("t4_done_cycle", 32'(off), 32'(18));
`ifdef BUF_CTRL_PERF_EN
        chk("t4_stall_cnt", 32'(stall_cnt), 32'(5));
`endif
        tick();

        // Reset after the first pair has been issued.
        d0 = mon_done; t0 = mon_stream;
        start = 1'b1; load_len = 15'd4; drive(0, 0); tick();
        for (int k = 1; k <= 7; k++) begin drive(0, k); tick(); end
        chk("t5_one_pair", 32'(mon_stream - t0), 32'(1));
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_buf_state", 32'(buf_state), 32'(0));
        chk("t5_out_valid", 32'(out_valid), 32'(0));
        go_idle();
        repeat (10) tick();
        chk("t5_no_done", 32'(mon_done - d0), 32'(0));
        run_job(2, 0, 100, off);
        chk("t5_len2_done_cycle", 32'(off), 32'(7));
        tick();

        // Randomised jobs with random flags, ignored starts and rejected starts between jobs.
        for (int j = 0; j < 10; j++) begin
            len = 2 * int'($urandom_range(1, 40));
            d0 = mon_done;
            run_job(len, 3, 4000, off);
            chk("rand_done", 32'(mon_done - d0), 32'(1));
            start = 1'b1; load_len = 15'(2 * $urandom_range(0, 9) + 1); tick();
            start = 1'b0; tick();
        end

        // Full-depth job.
        s0 = mon_store; t0 = mon_stream; d0 = mon_done;
        run_job(int'(DEPTH), 4, 30000, off);
        chk("t6_stores", 32'(mon_store - s0), 32'(16384));
        chk("t6_streams", 32'(mon_stream - t0), 32'(8192));
        chk("t6_done", 32'(mon_done - d0), 32'(1));
        chk("t6_done_cycle", 32'(off), 32'(24580));
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
